int_stack_sequencer: RTL and testbench
======================================

// Module: int_stack_sequencer
// PURPOSE
//  Multi-cycle controller for every stack-touching control transfer: CALL, RET, RTI and hardware INT.
//  Sits beside the decode stage. Consumes the CU's stack commands (Stack_PC / Stack_Flags class ops) and the INT pin.
//  Stalls the front end while it works, drives the data-memory port one 16-bit word at a time, and owns SP.
//  When finished it loads PC and, for RTI, the flags.
// PARAMETERS
//  PC_W     32     program counter width; pushed and popped as two words, high word pushed first
//  DATA_W   16     memory word width
//  ADDR_W   11     data-memory address width; SP width
//  FLAG_W   3      flags {C,N,Z}, zero-extended to one word on push
//  SP_INIT  2047   SP value after reset; points at the next free word
//  INT_VEC  0      address of the interrupt vector: M[INT_VEC]=PC hi, M[INT_VEC+1]=PC lo
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  INT        in   1       interrupt request, level, sampled every clk
//  cmd_valid  in   1       decode presents a stack command
//  cmd_ready  out  1       command accepted on (cmd_valid && cmd_ready)
//  cmd_op     in   2       01=CALL, 10=RET, 11=RTI; 00 is illegal and is ignored
//  ret_pc     in   PC_W    PC to resume at (CALL return address / INT resume point)
//  call_tgt   in   PC_W    CALL target
//  flags_in   in   FLAG_W  current flags (pushed by INT)
//  busy       out  1       stall fetch/decode
//  pc_load    out  1       1-cycle pulse: PC <= pc_value
//  pc_value   out  PC_W
//  flags_load out  1       1-cycle pulse: flags <= flags_value (RTI only)
//  flags_value out FLAG_W
//  int_ack    out  1       1-cycle pulse on the INT service pc_load
//  sp         out  ADDR_W  current stack pointer
//  mem_req    out  1       memory transfer request
//  mem_we     out  1       1=write
//  mem_addr   out  ADDR_W
//  mem_wdata  out  DATA_W
//  mem_rdata  in   DATA_W  valid when mem_ack=1 on a read
//  mem_ack    in   1       transfer completes on any edge with mem_req && mem_ack
// BEHAVIOUR
//  Reset: state IDLE; sp=SP_INIT; int_pend=0; all pulses, mem_*, busy, pc_value and flags_value are 0; cmd_ready=1.
//  Push: write M[sp], then sp <= sp-1. Pop: read M[sp+1], then sp <= sp+1. SP changes only on a completed transfer.
//  SP wraps modulo 2^ADDR_W with no error indication.
//  Handshake:
//    - mem_addr, mem_we and mem_wdata are held stable while mem_req=1 && !mem_ack.
//    - mem_ack is ignored when mem_req=0.
//    - There is at most one outstanding transfer.
//  INT: a rising INT sets int_pend (sticky); it is cleared on int_ack. INT while int_pend=1 is not counted twice.
//  In IDLE, int_pend beats cmd_valid: cmd_ready=0 that cycle and the command waits.
//  cmd_ready = (state==IDLE) && !int_pend. busy = (state!=IDLE) || int_pend || (cmd_valid && cmd_ready).
//  FSM sequences (each memory state waits for mem_ack):
//    CALL: PUSH_PCH(ret_pc hi) -> PUSH_PCL -> LOAD(pc_value=call_tgt) -> IDLE
//    RET : POP_PCL -> POP_PCH -> LOAD(pc_value={hi,lo}) -> IDLE
//    RTI : POP_FLG -> POP_PCL -> POP_PCH -> LOAD(+flags_load, flags_value=popped word[FLAG_W-1:0]) -> IDLE
//    INT : PUSH_PCH -> PUSH_PCL -> PUSH_FLG -> VEC_H(read INT_VEC) -> VEC_L(read INT_VEC+1) -> LOAD(+int_ack) -> IDLE
//  Operands: ret_pc, call_tgt and flags_in are captured into internal registers on acceptance.
//  Vector reads do not touch SP.
//  Latency with mem_ack tied 1, counted in cycles from the acceptance edge to the pc_load cycle:
//    CALL 3, RET 3, RTI 4, INT 6.
//  An INT arriving mid-sequence is latched and serviced immediately after that sequence's LOAD.
//  The command sequence is never aborted.
//  cmd_op=00 is accepted and dropped: no state change, no pulses.
//  Asynchronous reset mid-sequence returns to reset values at once. A partially written stack is not repaired.
// STRUCTURE
//  Shared include (stack_defs.vh): cmd_op encodings, FSM state codes, INT_VEC, SP_INIT.
//  One sub-module, sp_unit: SP register with inc/dec/hold, next-free and top-of-stack address outputs.
//  FSM, operand capture, int_pend and the memory-port mux stay in int_stack_sequencer.
// TESTING
//  1 Reset with rst_n=0 mid-CALL (after PUSH_PCH) -> sp=2047, mem_req=0, cmd_ready=1 immediately; no pc_load.
//  2 CALL with ret_pc=0x0001_0020, call_tgt=0x0000_0100, mem_ack=1:
//    -> writes M[2047]=0x0001, then M[2046]=0x0020; sp=2045; pc_load with pc_value=0x100 3 cycles after accept.
//  3 RET following test 2:
//    -> reads 2046 then 2047; pc_value=0x0001_0020; sp=2047.
//  4 INT with flags_in=3'b101, ret_pc=0x40, M[0]=0x0000, M[1]=0x0200:
//    -> writes 0x0000, 0x0040, 0x0005 at 2047..2045; pc_value=0x200 with int_ack; then RTI restores flags 101 and PC 0x40.
//  5 INT and cmd_valid(CALL) in the same IDLE cycle -> INT sequence runs first; CALL is accepted the cycle after int_ack.
//  6 mem_ack held low 3 cycles during PUSH_PCL -> mem_addr and mem_wdata stable; sp unchanged until ack.
//  7 Ten CALLs from sp=4 -> sp wraps through 0 to 2047 with no error; addresses wrap modulo 2048.

Source files
------------

// File: rtl/int_stack_sequencer_pkg.sv
// Shared encodings for the stack sequencer: command opcodes, FSM states,
// sequence kinds and the default geometry of the stack and vector.
package int_stack_sequencer_pkg;

    localparam int DEF_PC_W    = 32;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ADDR_W  = 11;
    localparam int DEF_FLAG_W  = 3;
    localparam int DEF_SP_INIT = 2047;
    localparam int DEF_INT_VEC = 0;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_CALL = 2'b01,
        OP_RET  = 2'b10,
        OP_RTI  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        K_CALL = 2'd0,
        K_RET  = 2'd1,
        K_RTI  = 2'd2,
        K_INT  = 2'd3
    } kind_e;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_PUSH_PCH = 4'd1,
        S_PUSH_PCL = 4'd2,
        S_PUSH_FLG = 4'd3,
        S_POP_FLG  = 4'd4,
        S_POP_PCL  = 4'd5,
        S_POP_PCH  = 4'd6,
        S_VEC_H    = 4'd7,
        S_VEC_L    = 4'd8,
        S_LOAD     = 4'd9
    } state_e;

endpackage

// File: rtl/int_stack_sequencer_sp_unit.sv
// Stack pointer register: one step up or down per completed transfer,
// exposing next-free (push) and top-of-stack (pop) addresses.
module int_stack_sequencer_sp_unit
    import int_stack_sequencer_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int SP_INIT = DEF_SP_INIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_inc,
    input  logic              i_dec,
    output logic [ADDR_W-1:0] o_sp,
    output logic [ADDR_W-1:0] o_free,
    output logic [ADDR_W-1:0] o_top
);

    logic [ADDR_W-1:0] r_sp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp <= ADDR_W'(SP_INIT);
        end else begin
            unique case (1'b1)
                i_inc:   r_sp <= r_sp + ADDR_W'(1);
                i_dec:   r_sp <= r_sp - ADDR_W'(1);
                default: r_sp <= r_sp;
            endcase
        end
    end

    // Wrap modulo 2^ADDR_W falls out of the fixed-width arithmetic.
    assign o_sp   = r_sp;
    assign o_free = r_sp;
    assign o_top  = r_sp + ADDR_W'(1);

endmodule

// File: rtl/int_stack_sequencer.sv
// Multi-cycle CALL/RET/RTI/INT controller: owns SP, walks the stack one
// word per transfer and finishes with a PC (and for RTI, flags) load.
module int_stack_sequencer
    import int_stack_sequencer_pkg::*;
#(
    parameter int PC_W    = DEF_PC_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int FLAG_W  = DEF_FLAG_W,
    parameter int SP_INIT = DEF_SP_INIT,
    parameter int INT_VEC = DEF_INT_VEC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              INT,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [PC_W-1:0]   ret_pc,
    input  logic [PC_W-1:0]   call_tgt,
    input  logic [FLAG_W-1:0] flags_in,
    output logic              busy,
    output logic              pc_load,
    output logic [PC_W-1:0]   pc_value,
    output logic              flags_load,
    output logic [FLAG_W-1:0] flags_value,
    output logic              int_ack,
    output logic [ADDR_W-1:0] sp,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    state_e            r_state;
    state_e            w_next;
    kind_e             r_kind;
    kind_e             w_next_kind;
    logic              r_int_q;
    logic              r_int_pend;
    logic [PC_W-1:0]   r_ret_pc;
    logic [PC_W-1:0]   r_pc_tgt;
    logic [FLAG_W-1:0] r_flags_in;
    logic [FLAG_W-1:0] r_flags_pop;

    logic              w_idle;
    logic              w_load;
    logic              w_int_rise;
    logic              w_int_pend;
    logic              w_accept;
    logic              w_xfer;
    logic              w_sp_inc;
    logic              w_sp_dec;
    logic [ADDR_W-1:0] w_sp_free;
    logic [ADDR_W-1:0] w_sp_top;

    int_stack_sequencer_sp_unit #(
        .ADDR_W  (ADDR_W),
        .SP_INIT (SP_INIT)
    ) u_sp (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_inc  (w_sp_inc),
        .i_dec  (w_sp_dec),
        .o_sp   (sp),
        .o_free (w_sp_free),
        .o_top  (w_sp_top)
    );

    // A same-cycle rising INT already outranks a waiting command.
    assign w_int_rise = INT && !r_int_q;
    assign w_int_pend = r_int_pend || w_int_rise;
    assign w_idle     = (r_state == S_IDLE);
    assign w_load     = (r_state == S_LOAD);
    assign cmd_ready  = w_idle && !w_int_pend;
    assign w_accept   = cmd_valid && cmd_ready;
    assign busy       = !w_idle || w_int_pend || w_accept;
    assign w_xfer     = mem_req && mem_ack;

    assign pc_load     = w_load;
    assign int_ack     = w_load && (r_kind == K_INT);
    assign flags_load  = w_load && (r_kind == K_RTI);
    assign pc_value    = w_load ? r_pc_tgt : '0;
    assign flags_value = flags_load ? r_flags_pop : '0;

    always_comb begin
        w_next      = r_state;
        w_next_kind = r_kind;
        unique case (r_state)
            S_IDLE: begin
                if (w_int_pend) begin
                    w_next      = S_PUSH_PCH;
                    w_next_kind = K_INT;
                end else if (cmd_valid) begin
                    unique case (cmd_op)
                        OP_CALL: begin
                            w_next      = S_PUSH_PCH;
                            w_next_kind = K_CALL;
                        end
                        OP_RET: begin
                            w_next      = S_POP_PCL;
                            w_next_kind = K_RET;
                        end
                        OP_RTI: begin
                            w_next      = S_POP_FLG;
                            w_next_kind = K_RTI;
                        end
                        default: w_next = S_IDLE;
                    endcase
                end
            end
            S_PUSH_PCH: if (w_xfer) w_next = S_PUSH_PCL;
            S_PUSH_PCL: begin
                if (w_xfer)
                    w_next = (r_kind == K_INT) ? S_PUSH_FLG : S_LOAD;
            end
            S_PUSH_FLG: if (w_xfer) w_next = S_VEC_H;
            S_VEC_H:    if (w_xfer) w_next = S_VEC_L;
            S_VEC_L:    if (w_xfer) w_next = S_LOAD;
            S_POP_FLG:  if (w_xfer) w_next = S_POP_PCL;
            S_POP_PCL:  if (w_xfer) w_next = S_POP_PCH;
            S_POP_PCH:  if (w_xfer) w_next = S_LOAD;
            S_LOAD:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Port fields come only from state and registers, so they hold while stalled.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (r_state)
            S_PUSH_PCH: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = w_sp_free;
                mem_wdata = r_ret_pc[PC_W-1:DATA_W];
            end
            S_PUSH_PCL: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = w_sp_free;
                mem_wdata = r_ret_pc[DATA_W-1:0];
            end
            S_PUSH_FLG: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = w_sp_free;
                mem_wdata = DATA_W'(r_flags_in);
            end
            S_POP_FLG, S_POP_PCL, S_POP_PCH: begin
                mem_req  = 1'b1;
                mem_addr = w_sp_top;
            end
            S_VEC_H: begin
                mem_req  = 1'b1;
                mem_addr = ADDR_W'(INT_VEC);
            end
            S_VEC_L: begin
                mem_req  = 1'b1;
                mem_addr = ADDR_W'(INT_VEC) + ADDR_W'(1);
            end
            default: mem_req = 1'b0;
        endcase
    end

    assign w_sp_dec = w_xfer && mem_we;
    assign w_sp_inc = w_xfer && !mem_we
                   && (r_state != S_VEC_H) && (r_state != S_VEC_L);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_kind      <= K_CALL;
            r_int_q     <= 1'b0;
            r_int_pend  <= 1'b0;
            r_ret_pc    <= '0;
            r_pc_tgt    <= '0;
            r_flags_in  <= '0;
            r_flags_pop <= '0;
        end else begin
            r_state    <= w_next;
            r_kind     <= w_next_kind;
            r_int_q    <= INT;
            r_int_pend <= int_ack ? 1'b0 : w_int_pend;
            if (w_idle && w_int_pend) begin
                r_ret_pc   <= ret_pc;
                r_flags_in <= flags_in;
            end else if (w_accept && (cmd_op == OP_CALL)) begin
                r_ret_pc <= ret_pc;
                r_pc_tgt <= call_tgt;
            end
            if (w_xfer && !mem_we) begin
                unique case (r_state)
                    S_POP_FLG:
                        r_flags_pop <= mem_rdata[FLAG_W-1:0];
                    S_POP_PCL, S_VEC_L:
                        r_pc_tgt[DATA_W-1:0] <= mem_rdata;
                    S_POP_PCH, S_VEC_H:
                        r_pc_tgt[PC_W-1:DATA_W] <= mem_rdata;
                    default: r_pc_tgt <= r_pc_tgt;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_int_stack_sequencer.sv
// Directed bench for int_stack_sequencer: a word-wide memory model with
// controllable ack, plus one task per scenario with hand-computed results.
module tb_int_stack_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        INT = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [31:0] ret_pc = '0;
    logic [31:0] call_tgt = '0;
    logic [2:0]  flags_in = '0;
    logic        busy;
    logic        pc_load;
    logic [31:0] pc_value;
    logic        flags_load;
    logic [2:0]  flags_value;
    logic        int_ack;
    logic [10:0] sp;
    logic        mem_req;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        ack_en = 1'b1;

    logic [15:0] mem [0:2047];
    logic [26:0] wlog[$];
    logic [10:0] rlog[$];

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign mem_ack   = ack_en;
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (rst_n && mem_req && mem_ack) begin
            if (mem_we) begin
                mem[mem_addr] = mem_wdata;
                wlog.push_back({mem_addr, mem_wdata});
            end else begin
                rlog.push_back(mem_addr);
            end
        end
    end

    int_stack_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .INT         (INT),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .ret_pc      (ret_pc),
        .call_tgt    (call_tgt),
        .flags_in    (flags_in),
        .busy        (busy),
        .pc_load     (pc_load),
        .pc_value    (pc_value),
        .flags_load  (flags_load),
        .flags_value (flags_value),
        .int_ack     (int_ack),
        .sp          (sp),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Cycle 1 is the cycle right after the accepting edge.
    task automatic wait_load(output int cyc);
        cyc = 1;
        while (!pc_load && cyc < 30) begin
            tick();
            cyc++;
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] rp,
                         input logic [31:0] tg, output int cyc);
        cmd_valid = 1'b1;
        cmd_op    = op;
        ret_pc    = rp;
        call_tgt  = tg;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        wait_load(cyc);
    endtask

    task automatic do_reset;
        rst_n     = 1'b0;
        INT       = 1'b0;
        cmd_valid = 1'b0;
        ack_en    = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        int loads;
        rst_n = 1'b0;
        repeat (2) tick();
        n_total++; if (sp !== 11'd2047) $display("FAIL reset_sp got %0d exp 2047", sp); else n_pass++;
        n_total++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", cmd_ready); else n_pass++;
        n_total++; if ({mem_req, busy, pc_load, int_ack, flags_load} !== 5'b0)
            $display("FAIL reset_pulses got %b exp 00000", {mem_req, busy, pc_load, int_ack, flags_load}); else n_pass++;
        n_total++; if (pc_value !== 32'h0) $display("FAIL reset_pcv got %h exp 0", pc_value); else n_pass++;
        rst_n = 1'b1;
        tick();
        cmd_valid = 1'b1; cmd_op = 2'b01; ret_pc = 32'h0001_0020; call_tgt = 32'h100;
        tick();
        cmd_valid = 1'b0;
        tick();
        n_total++; if (sp !== 11'd2046) $display("FAIL midcall_sp got %0d exp 2046", sp); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (sp !== 11'd2047) $display("FAIL async_sp got %0d exp 2047", sp); else n_pass++;
        n_total++; if (mem_req !== 1'b0) $display("FAIL async_req got %b exp 0", mem_req); else n_pass++;
        n_total++; if (cmd_ready !== 1'b1) $display("FAIL async_ready got %b exp 1", cmd_ready); else n_pass++;
        loads = 0;
        repeat (3) begin tick(); if (pc_load) loads++; end
        rst_n = 1'b1;
        repeat (3) begin tick(); if (pc_load) loads++; end
        n_total++; if (loads !== 0) $display("FAIL async_noload got %0d exp 0", loads); else n_pass++;
    endtask

    task automatic test_call;
        int cyc;
        logic [26:0] exp_w [2];
        exp_w[0] = {11'd2047, 16'h0001};
        exp_w[1] = {11'd2046, 16'h0020};
        wlog.delete();
        issue(2'b01, 32'h0001_0020, 32'h0000_0100, cyc);
        n_total++; if (cyc !== 3) $display("FAIL call_latency got %0d exp 3", cyc); else n_pass++;
        n_total++; if (pc_value !== 32'h100) $display("FAIL call_pcv got %h exp 100", pc_value); else n_pass++;
        n_total++; if ({int_ack, flags_load} !== 2'b00) $display("FAIL call_side got %b exp 00", {int_ack, flags_load}); else n_pass++;
        n_total++; if (sp !== 11'd2045) $display("FAIL call_sp got %0d exp 2045", sp); else n_pass++;
        n_total++; if (wlog.size() !== 2) $display("FAIL call_nwr got %0d exp 2", wlog.size()); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            logic [26:0] got;
            got = (i < wlog.size()) ? wlog[i] : 27'h7ffffff;
            n_total++; if (got !== exp_w[i]) $display("FAIL call_wr%0d got %h exp %h", i, got, exp_w[i]); else n_pass++;
        end
        tick();
        n_total++; if ({cmd_ready, busy} !== 2'b10) $display("FAIL call_idle got %b exp 10", {cmd_ready, busy}); else n_pass++;
    endtask

    task automatic test_ret;
        int cyc;
        rlog.delete();
        issue(2'b10, 32'h0, 32'h0, cyc);
        n_total++; if (cyc !== 3) $display("FAIL ret_latency got %0d exp 3", cyc); else n_pass++;
        n_total++; if (pc_value !== 32'h0001_0020) $display("FAIL ret_pcv got %h exp 00010020", pc_value); else n_pass++;
        n_total++; if (sp !== 11'd2047) $display("FAIL ret_sp got %0d exp 2047", sp); else n_pass++;
        n_total++; if ({rlog.size() == 2, (rlog.size() == 2) ? {rlog[0], rlog[1]} : 22'h0} !== {1'b1, 11'd2046, 11'd2047})
            $display("FAIL ret_rd got n=%0d exp 2046,2047", rlog.size()); else n_pass++;
        tick();
    endtask

    task automatic test_int_rti;
        int cyc;
        logic [26:0] exp_w [3];
        exp_w[0] = {11'd2047, 16'h0000};
        exp_w[1] = {11'd2046, 16'h0040};
        exp_w[2] = {11'd2045, 16'h0005};
        mem[0] = 16'h0000;
        mem[1] = 16'h0200;
        wlog.delete();
        rlog.delete();
        flags_in = 3'b101;
        ret_pc   = 32'h40;
        INT      = 1'b1;
        #1;
        n_total++; if ({cmd_ready, busy} !== 2'b01) $display("FAIL int_stall got %b exp 01", {cmd_ready, busy}); else n_pass++;
        tick();
        wait_load(cyc);
        n_total++; if (cyc !== 6) $display("FAIL int_latency got %0d exp 6", cyc); else n_pass++;
        n_total++; if ({int_ack, flags_load} !== 2'b10) $display("FAIL int_ack got %b exp 10", {int_ack, flags_load}); else n_pass++;
        n_total++; if (pc_value !== 32'h200) $display("FAIL int_pcv got %h exp 200", pc_value); else n_pass++;
        n_total++; if (sp !== 11'd2044) $display("FAIL int_sp got %0d exp 2044", sp); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            logic [26:0] got;
            got = (i < wlog.size()) ? wlog[i] : 27'h7ffffff;
            n_total++; if (got !== exp_w[i]) $display("FAIL int_wr%0d got %h exp %h", i, got, exp_w[i]); else n_pass++;
        end
        n_total++; if ({rlog.size() == 2, (rlog.size() == 2) ? {rlog[0], rlog[1]} : 22'h0} !== {1'b1, 11'd0, 11'd1})
            $display("FAIL int_vec got n=%0d exp 0,1", rlog.size()); else n_pass++;
        INT      = 1'b0;
        flags_in = 3'b000;
        tick();
        n_total++; if ({cmd_ready, int_ack} !== 2'b10) $display("FAIL int_after got %b exp 10", {cmd_ready, int_ack}); else n_pass++;
        issue(2'b11, 32'h0, 32'h0, cyc);
        n_total++; if (cyc !== 4) $display("FAIL rti_latency got %0d exp 4", cyc); else n_pass++;
        n_total++; if ({flags_load, int_ack} !== 2'b10) $display("FAIL rti_pulse got %b exp 10", {flags_load, int_ack}); else n_pass++;
        n_total++; if (flags_value !== 3'b101) $display("FAIL rti_flags got %b exp 101", flags_value); else n_pass++;
        n_total++; if (pc_value !== 32'h40) $display("FAIL rti_pcv got %h exp 40", pc_value); else n_pass++;
        n_total++; if (sp !== 11'd2047) $display("FAIL rti_sp got %0d exp 2047", sp); else n_pass++;
        tick();
    endtask

    task automatic test_int_vs_cmd;
        int cyc;
        INT       = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        ret_pc    = 32'h77;
        call_tgt  = 32'h300;
        flags_in  = 3'b010;
        #1;
        n_total++; if (cmd_ready !== 1'b0) $display("FAIL prio_ready got %b exp 0", cmd_ready); else n_pass++;
        tick();
        wait_load(cyc);
        n_total++; if (cyc !== 6) $display("FAIL prio_latency got %0d exp 6", cyc); else n_pass++;
        n_total++; if ({int_ack, pc_value} !== {1'b1, 32'h200}) $display("FAIL prio_int got %b/%h exp 1/200", int_ack, pc_value); else n_pass++;
        tick();
        n_total++; if (cmd_ready !== 1'b1) $display("FAIL prio_accept got %b exp 1", cmd_ready); else n_pass++;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        wait_load(cyc);
        n_total++; if (cyc !== 3) $display("FAIL prio_call_lat got %0d exp 3", cyc); else n_pass++;
        n_total++; if ({int_ack, pc_value} !== {1'b0, 32'h300}) $display("FAIL prio_call got %b/%h exp 0/300", int_ack, pc_value); else n_pass++;
        n_total++; if (sp !== 11'd2042) $display("FAIL prio_sp got %0d exp 2042", sp); else n_pass++;
        INT = 1'b0;
        tick();
    endtask

    task automatic test_ack_stall;
        int cyc;
        do_reset();
        cmd_valid = 1'b1; cmd_op = 2'b01; ret_pc = 32'hABCD_1234; call_tgt = 32'h500;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        tick();
        ack_en = 1'b0;
        repeat (3) begin
            tick();
            n_total++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 11'd2046, 16'h1234})
                $display("FAIL stall_port got %b%b/%0d/%h exp 11/2046/1234", mem_req, mem_we, mem_addr, mem_wdata); else n_pass++;
            n_total++; if (sp !== 11'd2046) $display("FAIL stall_sp got %0d exp 2046", sp); else n_pass++;
        end
        ack_en = 1'b1;
        wait_load(cyc);
        n_total++; if ({pc_load, pc_value} !== {1'b1, 32'h500}) $display("FAIL stall_load got %b/%h exp 1/500", pc_load, pc_value); else n_pass++;
        n_total++; if (sp !== 11'd2045) $display("FAIL stall_sp_end got %0d exp 2045", sp); else n_pass++;
        n_total++; if (mem[2046] !== 16'h1234) $display("FAIL stall_mem got %h exp 1234", mem[2046]); else n_pass++;
        tick();
    endtask

    task automatic test_wrap;
        int cyc;
        logic [31:0] last_pc;
        do_reset();
        rlog.delete();
        issue(2'b10, 32'h0, 32'h0, cyc);
        n_total++; if (pc_value !== 32'h0200_0000) $display("FAIL wrap_ret_pcv got %h exp 02000000", pc_value); else n_pass++;
        n_total++; if ({rlog.size() == 2, (rlog.size() == 2) ? {rlog[0], rlog[1]} : 22'h0} !== {1'b1, 11'd0, 11'd1})
            $display("FAIL wrap_ret_rd got n=%0d exp 0,1", rlog.size()); else n_pass++;
        n_total++; if (sp !== 11'd1) $display("FAIL wrap_ret_sp got %0d exp 1", sp); else n_pass++;
        tick();
        issue(2'b11, 32'h0, 32'h0, cyc);
        n_total++; if (sp !== 11'd4) $display("FAIL wrap_rti_sp got %0d exp 4", sp); else n_pass++;
        tick();
        wlog.delete();
        last_pc = '0;
        for (int i = 0; i < 10; i++) begin
            issue(2'b01, 32'(i), 32'h1000 + 32'(i), cyc);
            last_pc = pc_value;
            tick();
        end
        n_total++; if (sp !== 11'd2032) $display("FAIL wrap_sp got %0d exp 2032", sp); else n_pass++;
        n_total++; if (last_pc !== 32'h1009) $display("FAIL wrap_pcv got %h exp 1009", last_pc); else n_pass++;
        n_total++; if (wlog.size() !== 20) $display("FAIL wrap_nwr got %0d exp 20", wlog.size()); else n_pass++;
        n_total++; if ({(wlog.size() > 5) ? {wlog[4][26:16], wlog[5][26:16]} : 22'h3fffff} !== {11'd0, 11'd2047})
            $display("FAIL wrap_addr got n=%0d exp 0,2047", wlog.size()); else n_pass++;
    endtask

    task automatic test_nop;
        int ev;
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        #1;
        n_total++; if (cmd_ready !== 1'b1) $display("FAIL nop_ready got %b exp 1", cmd_ready); else n_pass++;
        tick();
        cmd_valid = 1'b0;
        ev = 0;
        repeat (4) begin
            if (pc_load || mem_req || flags_load || int_ack || !cmd_ready) ev++;
            tick();
        end
        n_total++; if (ev !== 0) $display("FAIL nop_activity got %0d exp 0", ev); else n_pass++;
        n_total++; if (sp !== 11'd2032) $display("FAIL nop_sp got %0d exp 2032", sp); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0;
        test_reset();
        test_call();
        test_ret();
        test_int_rti();
        test_int_vs_cmd();
        test_ack_stall();
        test_wrap();
        test_nop();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
